// File: rtl/apb_upsizer_param.sv
// rtl/apb_upsizer_param.sv - APB bridge from a narrow master to a wide slave, one beat per transfer.
// Optional slave-wait timeout: define APB_UPSIZER_TIMEOUT_EN.
module apb_upsizer_param #(
    parameter int ADDR_W    = 32,
    parameter int M_DW      = 16,
    parameter int S_DW      = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic                psel_m_i,
    input  logic                penable_m_i,
    input  logic                pwrite_m_i,
    input  logic [ADDR_W-1:0]   paddr_m_i,
    input  logic [M_DW-1:0]     pwdata_m_i,
    input  logic [M_DW/8-1:0]   pstrb_m_i,
    output logic [M_DW-1:0]     prdata_m_o,
    output logic                pready_m_o,
    output logic                pslverr_m_o,
    output logic                psel_s_o,
    output logic                penable_s_o,
    output logic                pwrite_s_o,
    output logic [ADDR_W-1:0]   paddr_s_o,
    output logic [S_DW-1:0]     pwdata_s_o,
    output logic [S_DW/8-1:0]   pstrb_s_o,
    input  logic [S_DW-1:0]     prdata_s_i,
    input  logic                pready_s_i,
    input  logic                pslverr_s_i
);

    localparam int R  = S_DW / M_DW;
    localparam int MB = $clog2(M_DW / 8);
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(S_DW / 8 - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [S_DW-1:0]     pwdata_q, pwdata_d;
    logic [S_DW/8-1:0]   pstrb_q, pstrb_d;
    logic [M_DW-1:0]     prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [LW-1:0]       lane;

`ifdef APB_UPSIZER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Capture happens on psel alone, so the master's enable phase carries no information here.
    logic unused_penable;
    assign unused_penable = penable_m_i;

    assign lane = (R > 1) ? LW'(paddr_m_i >> MB) : '0;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
`ifdef APB_UPSIZER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
`ifdef APB_UPSIZER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
`ifdef APB_UPSIZER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (psel_m_i) begin
                    pwrite_d  = pwrite_m_i;
                    paddr_d   = paddr_m_i & ~ALIGN_MASK;
                    pwdata_d  = S_DW'(pwdata_m_i) << (lane * M_DW);
                    pstrb_d   = (S_DW / 8)'(pstrb_m_i) << (lane * (M_DW / 8));
                    lane_d    = lane;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB_UPSIZER_TIMEOUT_EN
                cnt_d     = '0;
`endif
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_s_i) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        prdata_d = M_DW'(prdata_s_i >> (lane_q * M_DW));
                    end
                    pslverr_d = pslverr_s_i;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end
`ifdef APB_UPSIZER_TIMEOUT_EN
                // Expiry fires on the TO_CYCLES-th unanswered ACCESS cycle.
                else if (int'(cnt_q) + 1 >= TO_CYCLES) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign prdata_m_o  = prdata_q;
    assign pready_m_o  = pready_q;
    assign pslverr_m_o = pslverr_q;
    assign psel_s_o    = psel_q;
    assign penable_s_o = penable_q;
    assign pwrite_s_o  = pwrite_q;
    assign paddr_s_o   = paddr_q;
    assign pwdata_s_o  = pwdata_q;
    assign pstrb_s_o   = pstrb_q;

endmodule

// File: tb/tb_apb_upsizer_param.sv
// tb/tb_apb_upsizer_param.sv - scoreboard bench for apb_upsizer_param (16->32 and 8->32 instances).
module tb_apb_upsizer_param;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;

    logic        psel_m = 1'b0, penable_m = 1'b0, pwrite_m = 1'b0;
    logic [31:0] paddr_m = '0;
    logic [15:0] pwdata_m = '0;
    logic [1:0]  pstrb_m = '0;
    logic [15:0] prdata_m;
    logic        pready_m, pslverr_m, psel_s, penable_s, pwrite_s;
    logic [31:0] paddr_s, pwdata_s;
    logic [3:0]  pstrb_s;
    logic [31:0] prdata_s = '0;
    logic        pready_s = 1'b0, pslverr_s = 1'b0;

    logic        psel_m8 = 1'b0, penable_m8 = 1'b0, pwrite_m8 = 1'b0;
    logic [31:0] paddr_m8 = '0;
    logic [7:0]  pwdata_m8 = '0;
    logic [0:0]  pstrb_m8 = '0;
    logic [7:0]  prdata_m8;
    logic        pready_m8, pslverr_m8, psel_s8, penable_s8, pwrite_s8;
    logic [31:0] paddr_s8, pwdata_s8;
    logic [3:0]  pstrb_s8;
    logic [31:0] prdata_s8 = '0;
    logic        pready_s8 = 1'b0;

    apb_upsizer_param #(.ADDR_W(32), .M_DW(16), .S_DW(32), .TO_CYCLES(4)) dut (
        .pclk(pclk), .prst(prst),
        .psel_m_i(psel_m), .penable_m_i(penable_m), .pwrite_m_i(pwrite_m),
        .paddr_m_i(paddr_m), .pwdata_m_i(pwdata_m), .pstrb_m_i(pstrb_m),
        .prdata_m_o(prdata_m), .pready_m_o(pready_m), .pslverr_m_o(pslverr_m),
        .psel_s_o(psel_s), .penable_s_o(penable_s), .pwrite_s_o(pwrite_s),
        .paddr_s_o(paddr_s), .pwdata_s_o(pwdata_s), .pstrb_s_o(pstrb_s),
        .prdata_s_i(prdata_s), .pready_s_i(pready_s), .pslverr_s_i(pslverr_s)
    );

    apb_upsizer_param #(.ADDR_W(32), .M_DW(8), .S_DW(32), .TO_CYCLES(255)) dut8 (
        .pclk(pclk), .prst(prst),
        .psel_m_i(psel_m8), .penable_m_i(penable_m8), .pwrite_m_i(pwrite_m8),
        .paddr_m_i(paddr_m8), .pwdata_m_i(pwdata_m8), .pstrb_m_i(pstrb_m8),
        .prdata_m_o(prdata_m8), .pready_m_o(pready_m8), .pslverr_m_o(pslverr_m8),
        .psel_s_o(psel_s8), .penable_s_o(penable_s8), .pwrite_s_o(pwrite_s8),
        .paddr_s_o(paddr_s8), .pwdata_s_o(pwdata_s8), .pstrb_s_o(pstrb_s8),
        .prdata_s_i(prdata_s8), .pready_s_i(pready_s8), .pslverr_s_i(1'b0)
    );

    always #5 pclk = ~pclk;

    typedef struct {logic [15:0] rdata; logic err; int start; int lat;} mexp_t;
    typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;} sexp_t;

    mexp_t mq[$], mq8[$];
    sexp_t sq[$], sq8[$];
    int    checks = 0, errors = 0, cyc = 0;
    int    cur_wait = 0, wcnt = 0;
    logic [31:0] cur_rdata = '0, cur_rdata8 = '0;
    logic  cur_err = 1'b0, chk_slave = 1'b1, prev_rdy = 1'b0;
    mexp_t mon_e, mon_e8;
    sexp_t slv_e, slv_e8;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(posedge pclk) cyc++;

    // Wide slave model for the 16-bit instance; also checks what the bridge presents.
    always @(negedge pclk) begin
        if (psel_s === 1'b1 && penable_s === 1'b1) begin
            if (chk_slave) begin
                if (sq.size() == 0) chk("slave_unexpected", 64'(1), 64'(0));
                else begin
                    slv_e = sq[0];
                    chk("pwrite_s", 64'(pwrite_s), 64'(slv_e.wr));
                    chk("paddr_s", 64'(paddr_s), 64'(slv_e.addr));
                    chk("pwdata_s", 64'(pwdata_s), 64'(slv_e.wdata));
                    chk("pstrb_s", 64'(pstrb_s), 64'(slv_e.strb));
                end
            end
            if (wcnt >= cur_wait) begin
                pready_s  = 1'b1;
                prdata_s  = cur_rdata;
                pslverr_s = cur_err;
                if (chk_slave && sq.size() > 0) void'(sq.pop_front());
            end else begin
                pready_s = 1'b0;
                wcnt++;
            end
        end else begin
            pready_s  = 1'b0;
            pslverr_s = 1'b0;
            prdata_s  = 32'hA5A5_A5A5;
            wcnt      = 0;
        end
    end

    always @(negedge pclk) begin
        if (pready_m === 1'b1) begin
            if (mq.size() == 0) chk("pready_unexpected", 64'(1), 64'(0));
            else begin
                mon_e = mq.pop_front();
                chk("prdata_m", 64'(prdata_m), 64'(mon_e.rdata));
                chk("pslverr_m", 64'(pslverr_m), 64'(mon_e.err));
                chk("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
                chk("pready_pulse", 64'(prev_rdy), 64'(0));
            end
        end else if (pslverr_m !== 1'b0 && !prst) begin
            chk("pslverr_alone", 64'(pslverr_m), 64'(0));
        end
        prev_rdy = pready_m;
    end

    always @(negedge pclk) begin
        if (psel_s8 === 1'b1 && penable_s8 === 1'b1) begin
            if (sq8.size() == 0) chk("slave8_unexpected", 64'(1), 64'(0));
            else begin
                slv_e8 = sq8.pop_front();
                chk("paddr_s8", 64'(paddr_s8), 64'(slv_e8.addr));
                chk("pwdata_s8", 64'(pwdata_s8), 64'(slv_e8.wdata));
                chk("pstrb_s8", 64'(pstrb_s8), 64'(slv_e8.strb));
            end
            pready_s8 = 1'b1;
            prdata_s8 = cur_rdata8;
        end else begin
            pready_s8 = 1'b0;
            prdata_s8 = 32'h5A5A_5A5A;
        end
    end

    always @(negedge pclk) begin
        if (pready_m8 === 1'b1) begin
            if (mq8.size() == 0) chk("pready8_unexpected", 64'(1), 64'(0));
            else begin
                mon_e8 = mq8.pop_front();
                chk("prdata_m8", 64'(prdata_m8), 64'(mon_e8.rdata[7:0]));
            end
        end
    end

    task automatic wait_ready(input bit narrow);
        int n = 0;
        while (((narrow ? pready_m8 : pready_m) !== 1'b1) && n < 40) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 64'(1), 64'(0));
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                        input logic [1:0] st, input int wt, input logic [31:0] srd, input logic serr,
                        input logic [15:0] exp_rd, input logic exp_err, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wd, input logic [3:0] exp_st, input int exp_lat,
                        input bit drop_sel);
        @(negedge pclk);
        psel_m = 1'b1; penable_m = 1'b0; pwrite_m = wr;
        paddr_m = addr; pwdata_m = wd; pstrb_m = st;
        cur_wait = wt; cur_rdata = srd; cur_err = serr;
        mq.push_back('{exp_rd, exp_err, cyc, exp_lat});
        sq.push_back('{wr, exp_addr, exp_wd, exp_st});
        @(negedge pclk);
        penable_m = 1'b1;
        // Scramble master inputs after capture; the bridge must not follow them.
        pwrite_m = ~wr; paddr_m = ~addr; pwdata_m = ~wd; pstrb_m = ~st;
        if (drop_sel) begin psel_m = 1'b0; penable_m = 1'b0; end
        wait_ready(1'b0);
        psel_m = 1'b0; penable_m = 1'b0;
    endtask

    task automatic xfer8(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                         input logic st, input logic [31:0] srd, input logic [7:0] exp_rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wd, input logic [3:0] exp_st);
        @(negedge pclk);
        psel_m8 = 1'b1; penable_m8 = 1'b0; pwrite_m8 = wr;
        paddr_m8 = addr; pwdata_m8 = wd; pstrb_m8 = st;
        cur_rdata8 = srd;
        mq8.push_back('{{8'h00, exp_rd}, 1'b0, cyc, 3});
        sq8.push_back('{wr, exp_addr, exp_wd, exp_st});
        @(negedge pclk);
        penable_m8 = 1'b1;
        wait_ready(1'b1);
        psel_m8 = 1'b0; penable_m8 = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m"}, 64'({prdata_m, pready_m, pslverr_m}), 64'(0));
        chk({tag, "_s_ctl"}, 64'({psel_s, penable_s, pwrite_s, pstrb_s}), 64'(0));
        chk({tag, "_paddr"}, 64'(paddr_s), 64'(0));
        chk({tag, "_pwdata"}, 64'(pwdata_s), 64'(0));
        chk({tag, "_dut8"}, 64'({prdata_m8, pready_m8, psel_s8, pwrite_s8, paddr_s8, pwdata_s8}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge pclk);
        chk_all_zero("reset");
        prst = 1'b0;

        //   wr    addr          wd       st     wt  slave rdata    err   exp_rd    err   paddr_s       pwdata_s      pstrb  lat drop
        xfer(1'b1, 32'h0000_1002, 16'hABCD, 2'b11, 0, 32'h0,        1'b0, 16'h0000, 1'b0, 32'h0000_1000, 32'hABCD_0000, 4'b1100, 3, 0);
        xfer(1'b0, 32'h0000_1000, 16'h0000, 2'b00, 2, 32'h1234_5678, 1'b0, 16'h5678, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'b0000, 5, 0);
        xfer(1'b0, 32'h0000_2006, 16'h0000, 2'b00, 1, 32'hCAFE_F00D, 1'b0, 16'hCAFE, 1'b0, 32'h0000_2004, 32'h0000_0000, 4'b0000, 4, 1);
        xfer(1'b1, 32'h0000_2004, 16'h1234, 2'b01, 0, 32'h0,        1'b0, 16'hCAFE, 1'b0, 32'h0000_2004, 32'h0000_1234, 4'b0001, 3, 0);
        xfer(1'b1, 32'h0000_300A, 16'h5555, 2'b10, 0, 32'h0,        1'b1, 16'hCAFE, 1'b1, 32'h0000_3008, 32'h5555_0000, 4'b1000, 3, 0);
        xfer(1'b0, 32'h0000_3008, 16'h0000, 2'b00, 0, 32'h89AB_CDEF, 1'b1, 16'hCDEF, 1'b1, 32'h0000_3008, 32'h0000_0000, 4'b0000, 3, 0);
        xfer(1'b0, 32'hFFFF_FFFE, 16'h0000, 2'b00, 0, 32'h0F0F_1E1E, 1'b0, 16'h0F0F, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 3, 0);

        // Reset while the slave is stalling in ACCESS.
        @(negedge pclk);
        chk_slave = 1'b0; cur_wait = 20;
        psel_m = 1'b1; penable_m = 1'b0; pwrite_m = 1'b1;
        paddr_m = 32'h0000_5002; pwdata_m = 16'h1111; pstrb_m = 2'b11;
        @(negedge pclk);
        penable_m = 1'b1;
        @(negedge pclk);
        chk("pre_reset_access", 64'({psel_s, penable_s}), 64'(3));
        prst = 1'b1; psel_m = 1'b0; penable_m = 1'b0;
        @(negedge pclk);
        chk_all_zero("midreset");
        prst = 1'b0;
        repeat (4) @(negedge pclk);
        chk_slave = 1'b1;

        xfer(1'b0, 32'h0000_0000, 16'h0000, 2'b00, 0, 32'h0000_7777, 1'b0, 16'h7777, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 3, 0);
`ifdef APB_UPSIZER_TIMEOUT_EN
        xfer(1'b0, 32'h0000_0040, 16'h0000, 2'b00, 1000, 32'h1111_2222, 1'b0, 16'h0000, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'b0000, 6, 0);
        if (sq.size() > 0) void'(sq.pop_front());
`endif

        xfer8(1'b0, 32'h0000_0023, 8'h00, 1'b0, 32'hDEAD_BEEF, 8'hDE, 32'h0000_0020, 32'h0000_0000, 4'b0000);
        xfer8(1'b1, 32'h0000_0021, 8'h5A, 1'b1, 32'h0,         8'hDE, 32'h0000_0020, 32'h0000_5A00, 4'b0010);
        xfer8(1'b0, 32'h0000_0020, 8'h00, 1'b0, 32'hDEAD_BEEF, 8'hEF, 32'h0000_0020, 32'h0000_0000, 4'b0000);

        repeat (4) @(negedge pclk);
        chk("queues_drained", 64'(mq.size() + sq.size() + mq8.size() + sq8.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
